// File: rtl/audio_mixer_mac.sv
// N-channel stereo mixer: per-channel gain/mute through a time-multiplexed MAC, saturated to OUT_W.
// Optional clip counter ports enabled by defining AUDIO_MIXER_CLIP_COUNT_EN.
module audio_mixer_mac #(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 8,
  parameter int SIGNED_IN = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_stb_i,
  input  logic [NUM_CH*IN_W-1:0]   ch_l_i,
  input  logic [NUM_CH*IN_W-1:0]   ch_r_i,
  input  logic [NUM_CH*GAIN_W-1:0] gain_i,
  input  logic [NUM_CH-1:0]        mute_i,
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  input  logic                     clip_count_clr_i,
  output logic [15:0]              clip_count_o,
`endif
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [OUT_W-1:0]         audio_l_o,
  output logic [OUT_W-1:0]         audio_r_o,
  output logic                     clip_l_o,
  output logic                     clip_r_o,
  output logic                     overrun_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
  // Compare width always wider than both the accumulator and the clamp limits.
  localparam int CMP_W = ((ACC_W > OUT_W + 1) ? ACC_W : OUT_W + 1) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [NUM_CH*IN_W-1:0]   snap_l, snap_r;
  logic [NUM_CH*GAIN_W-1:0] snap_g;
  logic [NUM_CH-1:0]        snap_m;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc_l, acc_r, term_l, term_r;
  logic [OUT_W:0]           res_l, res_r;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic [IN_W-1:0] s,
                                                       input logic [GAIN_W-1:0] g,
                                                       input logic m);
    logic                    ext;
    logic signed [ACC_W-1:0] se, ge;
    if (SIGNED_IN != 0) begin
      ext = s[IN_W-1];
    end else begin
      ext = 1'b0;
    end
    se = {{(ACC_W-IN_W){ext}}, s};
    ge = {{(ACC_W-GAIN_W){1'b0}}, g};
    if (m) begin
      mac_term = '0;
    end else begin
      mac_term = se * ge;
    end
  endfunction

  // Returns {clip, sample}: accumulator scaled back to unity gain and clamped to the output range.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [CMP_W-1:0] ext, y, hi, lo;
    ext = {{(CMP_W-ACC_W){acc[ACC_W-1]}}, acc};
    y   = ext >>> (GAIN_W - 1);
    hi  = '0;
    hi[OUT_W-1:0] = '1;
    lo  = '0;
    if (SIGNED_IN != 0) begin
      hi[OUT_W-1] = 1'b0;
      lo = ~hi;
    end else begin
      lo = '0;
    end
    if (y > hi) begin
      scale_sat = {1'b1, hi[OUT_W-1:0]};
    end else if (y < lo) begin
      scale_sat = {1'b1, lo[OUT_W-1:0]};
    end else begin
      scale_sat = {1'b0, y[OUT_W-1:0]};
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sample_stb_i) next_state = ACC;
        else              next_state = IDLE;
      end
      ACC: begin
        if (idx == LAST_IDX) next_state = OUT;
        else                 next_state = ACC;
      end
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Current channel products and the saturated results of the finished sums.
  always_comb begin
    term_l = mac_term(snap_l[idx*IN_W +: IN_W], snap_g[idx*GAIN_W +: GAIN_W], snap_m[idx]);
    term_r = mac_term(snap_r[idx*IN_W +: IN_W], snap_g[idx*GAIN_W +: GAIN_W], snap_m[idx]);
    res_l  = scale_sat(acc_l);
    res_r  = scale_sat(acc_r);
  end

  // Snapshot, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_l    <= '0;
      snap_r    <= '0;
      snap_g    <= '0;
      snap_m    <= '0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      audio_l_o <= '0;
      audio_r_o <= '0;
      clip_l_o  <= 1'b0;
      clip_r_o  <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      overrun_o <= sample_stb_i && (state != IDLE);
      busy_o    <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (sample_stb_i) begin
            snap_l <= ch_l_i;
            snap_r <= ch_r_i;
            snap_g <= gain_i;
            snap_m <= mute_i;
            acc_l  <= '0;
            acc_r  <= '0;
            idx    <= '0;
          end
        end
        ACC: begin
          acc_l <= acc_l + term_l;
          acc_r <= acc_r + term_r;
          idx   <= idx + ONE_IDX;
        end
        OUT: begin
          {clip_l_o, audio_l_o} <= res_l;
          {clip_r_o, audio_r_o} <= res_r;
          valid_o               <= 1'b1;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  // Saturating count of clipped samples; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count_o <= 16'h0000;
    end else if (clip_count_clr_i) begin
      clip_count_o <= 16'h0000;
    end else if ((state == OUT) && (res_l[OUT_W] || res_r[OUT_W]) && (clip_count_o != 16'hFFFF)) begin
      clip_count_o <= clip_count_o + 16'h0001;
    end else begin
      clip_count_o <= clip_count_o;
    end
  end
`endif

endmodule

// File: tb/tb_audio_mixer_mac.sv
// Scoreboard bench for audio_mixer_mac: unsigned and signed instances share stimulus,
// expectations come from an arithmetic reference model, a monitor pops and compares on valid_o.
module tb_audio_mixer_mac;
  localparam int N = 4, IW = 16, OW = 16, GW = 8;

  logic clk = 1'b0, reset = 1'b1, stb = 1'b0;
  logic [N*IW-1:0] ch_l = '0, ch_r = '0;
  logic [N*GW-1:0] gain = '0;
  logic [N-1:0]    mute = '0;
  logic busy_u, valid_u, cl_u, cr_u, ov_u, busy_s, valid_s, cl_s, cr_s, ov_s;
  logic [OW-1:0] l_u, r_u, l_s, r_s;
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
  logic clr = 1'b0;
  logic [15:0] cnt_u, cnt_s;
`else
  logic [15:0] cnt_u = 16'd0, cnt_s = 16'd0;
`endif
  int exp_cnt [2] = '{0, 0};

  audio_mixer_mac #(.NUM_CH(N), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW), .SIGNED_IN(0)) dut_u (
    .clk(clk), .reset(reset), .sample_stb_i(stb), .ch_l_i(ch_l), .ch_r_i(ch_r),
    .gain_i(gain), .mute_i(mute),
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    .clip_count_clr_i(clr), .clip_count_o(cnt_u),
`endif
    .busy_o(busy_u), .valid_o(valid_u), .audio_l_o(l_u), .audio_r_o(r_u),
    .clip_l_o(cl_u), .clip_r_o(cr_u), .overrun_o(ov_u));

  audio_mixer_mac #(.NUM_CH(N), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW), .SIGNED_IN(1)) dut_s (
    .clk(clk), .reset(reset), .sample_stb_i(stb), .ch_l_i(ch_l), .ch_r_i(ch_r),
    .gain_i(gain), .mute_i(mute),
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    .clip_count_clr_i(clr), .clip_count_o(cnt_s),
`endif
    .busy_o(busy_s), .valid_o(valid_s), .audio_l_o(l_s), .audio_r_o(r_s),
    .clip_l_o(cl_s), .clip_r_o(cr_s), .overrun_o(ov_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [15:0] l, r;
    logic       cl, cr;
  } exp_t;

  exp_t q_u[$], q_s[$];
  int   ov_q[$];
  int   busy_lo = 0, busy_hi = -1, free_edge = 0;
  int   compared = 0, mismatched = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, act, exp);
    end
  endtask

  // Sum of sample*gain over unmuted channels, divided by unity gain (floor), clamped.
  function automatic void mix_side(input bit sgn, input logic [N*IW-1:0] ch,
                                   output logic [15:0] y, output logic c);
    longint sum = 0, a, v, lo, hi;
    for (int k = 0; k < N; k++) begin
      if (!mute[k]) begin
        if (sgn) a = longint'($signed(ch[k*IW +: IW]));
        else     a = longint'(ch[k*IW +: IW]);
        sum += a * longint'(gain[k*GW +: GW]);
      end
    end
    v  = sum >>> (GW - 1);
    lo = sgn ? -32768 : 0;
    hi = sgn ? 32767 : 65535;
    c  = (v < lo) || (v > hi);
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    y = 16'(v);
  endfunction

  function automatic exp_t model(input bit sgn, input int vc);
    exp_t e;
    e.cyc = vc;
    mix_side(sgn, ch_l, e.l, e.cl);
    mix_side(sgn, ch_r, e.r, e.cr);
    return e;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rnd_in();
    for (int k = 0; k < N; k++) begin
      ch_l[k*IW +: IW] = pick();
      ch_r[k*IW +: IW] = pick();
      gain[k*GW +: GW] = ($urandom_range(0, 3) == 0) ? 8'd128 : 8'($urandom);
    end
    mute = 4'($urandom) & 4'($urandom);
  endtask

  // One clock of stimulus; non-strobe cycles scramble inputs to prove the snapshot.
  task automatic tick(input bit s);
    int p;
    @(negedge clk);
    if (!s) rnd_in();
    stb = s;
    if (s) begin
      p = cyc + 1;
      if (p >= free_edge) begin
        q_u.push_back(model(1'b0, p + N + 1));
        q_s.push_back(model(1'b1, p + N + 1));
        busy_lo   = p;
        busy_hi   = p + N;
        free_edge = p + N + 2;
      end else begin
        ov_q.push_back(p);
      end
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [15:0] l, input logic [15:0] r,
                     input logic cl, input logic cr, input logic [15:0] cnt);
    exp_t e;
    int   sz;
    string sfx;
    sfx = (d == 0) ? "_u" : "_s";
    sz  = (d == 0) ? q_u.size() : q_s.size();
    if (v) begin
      if (sz == 0) begin
        chk({"unexpected_valid", sfx}, 32'd1, 32'd0);
      end else begin
        if (d == 0) e = q_u.pop_front();
        else        e = q_s.pop_front();
        chk({"latency", sfx}, cyc, e.cyc);
        chk({"audio_l", sfx}, l, e.l);
        chk({"audio_r", sfx}, r, e.r);
        chk({"clip_l", sfx}, cl, e.cl);
        chk({"clip_r", sfx}, cr, e.cr);
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
        if ((e.cl || e.cr) && exp_cnt[d] < 65535) exp_cnt[d]++;
        chk({"clip_count", sfx}, cnt, exp_cnt[d]);
`endif
      end
    end else if (sz > 0) begin
      if (d == 0) e = q_u[0];
      else        e = q_s[0];
      if (e.cyc <= cyc) begin
        chk({"missing_valid", sfx}, 32'd0, 32'd1);
        if (d == 0) void'(q_u.pop_front());
        else        void'(q_s.pop_front());
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic exp_ov, exp_busy;
    #1;
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    chk("busy_u", busy_u, exp_busy);
    chk("busy_s", busy_s, exp_busy);
    exp_ov = 1'b0;
    if (ov_q.size() > 0) begin
      if (ov_q[0] <= cyc) begin
        exp_ov = 1'b1;
        void'(ov_q.pop_front());
      end
    end
    if (ov_u || exp_ov) chk("overrun_u", ov_u, exp_ov);
    if (ov_s || exp_ov) chk("overrun_s", ov_s, exp_ov);
    mon(0, valid_u, l_u, r_u, cl_u, cr_u, cnt_u);
    mon(1, valid_s, l_s, r_s, cl_s, cr_s, cnt_s);
  end

  task automatic settle();
    repeat (N + 3) tick(1'b0);
  endtask

  task automatic all_gain(input logic [7:0] g);
    for (int k = 0; k < N; k++) gain[k*GW +: GW] = g;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_audio_l", l_u, 16'h0000);
    chk("rst_audio_r", r_s, 16'h0000);
    chk("rst_valid", {valid_u, valid_s, cl_u, cr_u, cl_s, cr_s}, 32'd0);
    chk("rst_busy", {busy_u, busy_s, ov_u, ov_s}, 32'd0);

    // Unity gain, one channel.
    all_gain(8'd128); mute = '0;
    ch_l = {16'd0, 16'd0, 16'd0, 16'd1000}; ch_r = '0;
    tick(1'b1); settle();
    chk("t1_audio_l", l_u, 16'd1000);
    chk("t1_audio_r", r_u, 16'd0);
    chk("t1_clip", {cl_u, cr_u}, 32'd0);

    // Half gain on ch1, muted full-scale ch0.
    all_gain(8'd128); gain[1*GW +: GW] = 8'd64; mute = 4'b0001;
    ch_l = {16'd0, 16'd0, 16'h8000, 16'hFFFF}; ch_r = '0;
    tick(1'b1); settle();
    chk("t2_audio_l", l_u, 16'h4000);
    chk("t2_clip_l", cl_u, 1'b0);
    chk("t2_audio_l_signed", l_s, 16'hC000);

    // Saturation on the left only.
    all_gain(8'd128); mute = '0;
    ch_l = {4{16'hC000}}; ch_r = '0;
    tick(1'b1); settle();
    chk("t3_audio_l", l_u, 16'hFFFF);
    chk("t3_clip", {cl_u, cr_u}, 32'b10);
    chk("t3_audio_l_signed", l_s, 16'h8000);
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
    chk("t3_count", cnt_u, 16'd1);
    @(negedge clk); clr = 1'b1; exp_cnt = '{0, 0};
    @(negedge clk); clr = 1'b0;
    chk("count_clear", cnt_u, 16'd0);
`endif

    // Overrun: second strobe two cycles after the first.
    all_gain(8'd128); mute = '0;
    ch_l = {16'd0, 16'd0, 16'd0, 16'd500}; ch_r = {16'd0, 16'd0, 16'd0, 16'd7};
    tick(1'b1); tick(1'b0); tick(1'b1); settle();
    chk("t4_audio_l", l_u, 16'd500);
    chk("t4_audio_r", r_u, 16'd7);

    // Reset three cycles into a mix.
    rnd_in();
    tick(1'b1); tick(1'b0); tick(1'b0);
    @(negedge clk);
    stb = 1'b0; reset = 1'b1;
    busy_hi = cyc; q_u.delete(); q_s.delete(); ov_q.delete(); free_edge = 0; exp_cnt = '{0, 0};
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", {busy_u, busy_s}, 32'd0);
    chk("t5_valid", {valid_u, valid_s}, 32'd0);
    chk("t5_audio", {l_u, r_u}, 32'd0);
    chk("t5_audio_s", {l_s, r_s}, 32'd0);
    rnd_in();
    tick(1'b1); settle();

    // Signed: two large negatives clamp, small negative passes.
    all_gain(8'd128); mute = '0;
    ch_l = {16'd0, 16'd0, 16'h8AD0, 16'h8AD0}; ch_r = '0;
    tick(1'b1); settle();
    chk("t6_audio_l_signed", l_s, 16'h8000);
    chk("t6_clip_l_signed", cl_s, 1'b1);
    ch_l = {16'd0, 16'd0, 16'd0, 16'hFF9C};
    tick(1'b1); settle();
    chk("t6b_audio_l_signed", l_s, 16'hFF9C);
    chk("t6b_clip_l_signed", cl_s, 1'b0);

    // Random strobes, including overruns and back-to-back acceptance.
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 3) == 0);
    // Exact back-to-back: strobe in the valid cycle.
    tick(1'b1);
    repeat (N) tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    settle();
    repeat (N + 3) tick(1'b0);
    chk("drain_u", q_u.size(), 32'd0);
    chk("drain_s", q_s.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
